// File: rtl/fpga_wr_pkg.sv
// Shared frame definitions for the FPGA<->DSP shared-RAM link.
// The transmit writer and the receive checker both import this package,
// so they agree on frame length, base address and interrupt width.
package fpga_wr_pkg;

    localparam int unsigned FRAME_NUM       = 32;
    localparam logic [9:0]  FRAME_BASE_ADDR = 10'h040;
    localparam int unsigned FRAME_INT_WIDTH = 100;
    localparam int unsigned CLK_HZ          = 100_000_000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUS,
        S_WRITE,
        S_INT
    } wr_state_e;

endpackage

// File: rtl/frame_csum.sv
// 16-bit wrap-around frame accumulator; csum_o is the inverted running sum,
// which is the value carried in the last word of a frame.
module frame_csum (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [15:0] data_i,
    output logic [15:0] csum_o
);

    logic [15:0] sum_q;
    logic [15:0] sum_d;

    // Next sum: clear wins over accumulate.
    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (en_i) begin
            sum_d = sum_q + data_i;
        end
    end

    // Sum register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign csum_o = ~sum_q;

endmodule

// File: rtl/fpga_wr.sv
// FPGA-to-DSP status uplink: snapshots status words, writes one checksummed
// frame into shared RAM (yielding to DSP accesses), then pulses xint_n low.
module fpga_wr
    import fpga_wr_pkg::*;
#(
    parameter int unsigned NUM       = FRAME_NUM,
    parameter logic [9:0]  BASE_ADDR = FRAME_BASE_ADDR,
    parameter int unsigned INT_WIDTH = FRAME_INT_WIDTH
) (
    input  logic                  clk_100M,
    input  logic                  reset,
    input  logic                  start,
    input  logic [(NUM-2)*16-1:0] status_flat,
    input  logic                  dsp_r,
    output logic [9:0]            addr_w,
    output logic [15:0]           ram_din,
    output logic                  ram_we,
    output logic                  xint_n,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int unsigned   KW     = $clog2(NUM);
    localparam int unsigned   CW     = $clog2(INT_WIDTH + 1);
    localparam logic [KW-1:0] K_LAST = KW'(NUM - 1);
    localparam logic [CW-1:0] C_LAST = CW'(INT_WIDTH - 1);

    wr_state_e             state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [15:0]           seq_q, seq_d;
    logic                  pend_q, pend_d;
    logic                  done_q, done_d;
    logic                  ovr_q, ovr_d;
    logic [(NUM-2)*16-1:0] snap_q, snap_d;

    logic        take;
    logic        queue;
    logic        csum_clr;
    logic        csum_en;
    logic [15:0] csum_n;
    logic [15:0] word_k;

    frame_csum u_csum (
        .clk_i  (clk_100M),
        .rst_i  (reset),
        .clr_i  (csum_clr),
        .en_i   (csum_en),
        .data_i (word_k),
        .csum_o (csum_n)
    );

    // Frame word k: sequence counter, snapshot words, then inverted sum.
    always_comb begin
        word_k = seq_q;
        for (int unsigned i = 0; i < NUM - 2; i++) begin
            if (k_q == KW'(i + 1)) begin
                word_k = snap_q[16*i +: 16];
            end
        end
        if (k_q == K_LAST) begin
            word_k = csum_n;
        end
    end

    // Request queueing and FSM next state / RAM port drive.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        seq_d    = seq_q;
        pend_d   = pend_q;
        snap_d   = snap_q;
        done_d   = 1'b0;
        ovr_d    = 1'b0;
        ram_we   = 1'b0;
        ram_din  = '0;
        csum_clr = 1'b0;
        csum_en  = 1'b0;

        // The done cycle is already IDLE, but a start seen there is queued
        // rather than taken, so it launches from IDLE one cycle later.
        take  = (state_q == S_IDLE) && (pend_q || (start && !done_q));
        queue = start && ((state_q != S_IDLE) || done_q);
        if (take) begin
            pend_d = 1'b0;
        end
        if (queue) begin
            if (pend_q && !take) begin
                ovr_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (take) begin
                    snap_d   = status_flat;
                    csum_clr = 1'b1;
                    state_d  = S_WAIT_BUS;
                end
            end
            S_WAIT_BUS: begin
                if (!dsp_r) begin
                    k_d     = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                ram_din = word_k;
                if (!dsp_r) begin
                    ram_we = 1'b1;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        cnt_d   = '0;
                        state_d = S_INT;
                    end else begin
                        csum_en = 1'b1;
                        k_d     = k_q + 1'b1;
                    end
                end
            end
            S_INT: begin
                if (cnt_q == C_LAST) begin
                    done_d  = 1'b1;
                    seq_d   = seq_q + 16'd1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_100M) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            seq_q   <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            snap_q  <= snap_d;
        end
    end

    assign addr_w  = BASE_ADDR + 10'(k_q);
    assign xint_n  = (state_q != S_INT);
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_fpga_wr.sv
// Directed bench for fpga_wr: shared-RAM model, receive-side checksum
// model, and hand-computed frame contents and timing.
module tb_fpga_wr;
    import fpga_wr_pkg::*;

    localparam int unsigned NW   = 32;
    localparam logic [9:0]  BASE = 10'h040;

    logic                 clk_100M = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 dsp_r;
    logic [(NW-2)*16-1:0] status_flat;
    logic [9:0]           addr_w;
    logic [15:0]          ram_din;
    logic                 ram_we;
    logic                 xint_n;
    logic                 busy;
    logic                 done;
    logic                 overrun;

    always #5 clk_100M = ~clk_100M;

    fpga_wr #(
        .NUM       (NW),
        .BASE_ADDR (BASE),
        .INT_WIDTH (100)
    ) dut (
        .clk_100M    (clk_100M),
        .reset       (reset),
        .start       (start),
        .status_flat (status_flat),
        .dsp_r       (dsp_r),
        .addr_w      (addr_w),
        .ram_din     (ram_din),
        .ram_we      (ram_we),
        .xint_n      (xint_n),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    logic [15:0] mem [0:1023];
    logic [9:0]  exp_addr = BASE;
    int unsigned cyc = 0, wr_cnt = 0, first_wr = 0, last_wr = 0;
    int unsigned addr_err = 0, we_dsp = 0, xlow = 0;
    int unsigned done_cnt = 0, ovr_cnt = 0, rx_frames = 0, rx_err = 0;
    int unsigned n_chk = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic rx_bad();
        logic [15:0] s;
        s = '0;
        for (int unsigned i = 0; i < NW - 1; i++) s = s + mem[BASE + 10'(i)];
        return (~s) != mem[BASE + 10'(NW - 1)];
    endfunction

    // Shared RAM write port, write-order tracking and receive checker.
    always @(posedge clk_100M) begin
        cyc = cyc + 1;
        if (ram_we) begin
            mem[addr_w] = ram_din;
            if (dsp_r) we_dsp++;
            if (addr_w != exp_addr) addr_err++;
            exp_addr = addr_w + 10'd1;
            if (wr_cnt == 0) first_wr = cyc;
            last_wr = cyc;
            wr_cnt++;
        end
        if (done) begin
            done_cnt++;
            rx_frames++;
            if (rx_bad()) rx_err++;
        end
        if (overrun) ovr_cnt++;
    end

    // Interrupt low-time counter.
    always @(negedge clk_100M) begin
        if (!xint_n) xlow++;
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk_100M);
    endtask

    task automatic new_frame();
        wr_cnt   = 0;
        exp_addr = BASE;
        xlow     = 0;
        first_wr = 0;
        last_wr  = 0;
    endtask

    // Returns the index of the clock edge that samples start.
    task automatic pulse_start(output int unsigned t);
        t = cyc + 1;
        start = 1'b1;
        @(negedge clk_100M);
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned max, input string tag);
        int unsigned n;
        n = 0;
        while (!done && n < max) begin
            @(negedge clk_100M);
            n++;
        end
        check_eq(tag, done, 1);
    endtask

    task automatic wait_wr(input int unsigned target, input string tag);
        int unsigned n;
        n = 0;
        while (wr_cnt < target && n < 200) begin
            @(negedge clk_100M);
            n++;
        end
        check_eq(tag, wr_cnt, target);
    endtask

    task automatic run_frame(input string tag, input logic [15:0] exp_seq,
                             input logic [15:0] exp_cs, input bit scramble);
        int unsigned t;
        new_frame();
        pulse_start(t);
        if (scramble) status_flat = ~status_flat;
        wait_done(400, {tag, "_done"});
        if (scramble) status_flat = ~status_flat;
        check_eq({tag, "_xint_at_done"}, xint_n, 1);
        check_eq({tag, "_busy_at_done"}, busy, 0);
        check_eq({tag, "_xlow"}, xlow, 100);
        check_eq({tag, "_nwr"}, wr_cnt, NW);
        check_eq({tag, "_first_wr"}, first_wr, t + 2);
        check_eq({tag, "_last_wr"}, last_wr, t + NW + 1);
        check_eq({tag, "_seq"}, mem[BASE], exp_seq);
        check_eq({tag, "_w5"}, mem[BASE + 10'd5], 16'h0005);
        check_eq({tag, "_csum"}, mem[BASE + 10'(NW - 1)], exp_cs);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t, w, d0;
        reset = 1'b1;
        start = 1'b0;
        dsp_r = 1'b0;
        for (int unsigned i = 0; i < NW - 2; i++) status_flat[16*i +: 16] = 16'(i + 1);
        for (int unsigned i = 0; i < 1024; i++) mem[i] = 16'hA5A5;
        tick(3);

        check_eq("rst_addr", addr_w, BASE);
        check_eq("rst_din", ram_din, 0);
        check_eq("rst_we", ram_we, 0);
        check_eq("rst_xint", xint_n, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ovr", overrun, 0);
        reset = 1'b0;
        tick(2);

        // Frame 1: words 1..30 = 1..30, sum 0x01D1.
        run_frame("f1", 16'h0000, 16'hFE2E, 1'b0);
        for (int unsigned i = 1; i < NW - 1; i++)
            check_eq("f1_word", mem[BASE + 10'(i)], i);
        tick(3);

        // Frame 2: status changes after start must not reach the frame.
        run_frame("f2", 16'h0001, 16'hFE2D, 1'b1);
        tick(3);

        // Sequence wrap.
        force dut.seq_q = 16'hFFFF;
        tick(1);
        release dut.seq_q;
        tick(1);
        run_frame("f3", 16'hFFFF, 16'hFE2F, 1'b0);
        tick(3);
        run_frame("f4", 16'h0000, 16'hFE2E, 1'b0);
        tick(3);

        // Frame 5: DSP holds the bus at start, then stalls mid-write.
        new_frame();
        dsp_r = 1'b1;
        pulse_start(t);
        tick(19);
        check_eq("stall_nwr_hold", wr_cnt, 0);
        check_eq("stall_busy", busy, 1);
        dsp_r = 1'b0;
        wait_wr(10, "stall_reach10");
        w = wr_cnt;
        dsp_r = 1'b1;
        tick(3);
        check_eq("stall_addr_hold", addr_w, BASE + 10'(w));
        check_eq("stall_we", ram_we, 0);
        tick(2);
        check_eq("stall_nwr_mid", wr_cnt, w);
        dsp_r = 1'b0;
        wait_done(400, "stall_done");
        check_eq("stall_we_dsp", we_dsp, 0);
        check_eq("stall_addr_err", addr_err, 0);
        check_eq("stall_nwr", wr_cnt, NW);
        check_eq("stall_xlow", xlow, 100);
        check_eq("stall_seq", mem[BASE], 16'h0001);
        check_eq("stall_csum", mem[BASE + 10'(NW - 1)], 16'hFE2D);
        tick(3);

        // Frames 6-8: pending, overrun and start-on-done queueing.
        new_frame();
        ovr_cnt = 0;
        d0 = done_cnt;
        pulse_start(t);
        while (cyc < t + 9) @(negedge clk_100M);
        start = 1'b1;
        @(negedge clk_100M);
        start = 1'b0;
        tick(1);
        check_eq("ovr_first_none", ovr_cnt, 0);
        start = 1'b1;
        @(negedge clk_100M);
        start = 1'b0;
        check_eq("ovr_pulse", overrun, 1);
        tick(2);
        check_eq("ovr_count", ovr_cnt, 1);
        wait_done(400, "f6_done");
        check_eq("f6_seq", mem[BASE], 16'h0002);
        check_eq("f6_busy_at_done", busy, 0);
        new_frame();
        tick(1);
        check_eq("f7_busy_after_done", busy, 1);
        wait_done(400, "f7_done");
        check_eq("f7_seq", mem[BASE], 16'h0003);
        check_eq("f7_nwr", wr_cnt, NW);
        new_frame();
        start = 1'b1;
        @(negedge clk_100M);
        start = 1'b0;
        check_eq("f8_queued_idle", busy, 0);
        tick(1);
        check_eq("f8_launched", busy, 1);
        wait_done(400, "f8_done");
        check_eq("f8_seq", mem[BASE], 16'h0004);
        tick(200);
        check_eq("extra_frames", done_cnt, d0 + 3);
        check_eq("ovr_total", ovr_cnt, 1);

        // Reset in the middle of the frame.
        new_frame();
        mem[BASE + 10'(NW - 1)] = 16'hBEEF;
        pulse_start(t);
        wait_wr(15, "mrst_reach15");
        reset = 1'b1;
        @(negedge clk_100M);
        check_eq("mrst_we", ram_we, 0);
        check_eq("mrst_xint", xint_n, 1);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_addr", addr_w, BASE);
        reset = 1'b0;
        d0 = done_cnt;
        xlow = 0;
        tick(200);
        check_eq("mrst_no_int", xlow, 0);
        check_eq("mrst_no_done", done_cnt, d0);
        check_eq("mrst_no_csum", mem[BASE + 10'(NW - 1)], 16'hBEEF);
        run_frame("post_rst", 16'h0000, 16'hFE2E, 1'b0);

        tick(5);
        check_eq("rx_err", rx_err, 0);
        check_eq("rx_frames", rx_frames, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fpga_wr.md
Name: fpga_wr

Overview:
FPGA-to-DSP status uplink: snapshots a block of status words and writes one checksummed frame into the shared dual-port RAM through the FPGA write port. It then pulses an active-low interrupt so the DSP fetches the frame. This is the transmit counterpart of the DSP-to-FPGA parameter download path. The frame format is identical: NUM words, with the last word equal to the bitwise NOT of the 16-bit sum of the preceding words.

Parameters:
NUM, 32, total frame words including sequence word and checksum word.
BASE_ADDR, 10'h040, shared-RAM address of frame word 0.
INT_WIDTH, 100, cycles xint_n is held low (1 us at 100 MHz).

Ports:
clk_100M  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to send a frame.
status_flat  in  (NUM-2)*16  status words; word i occupies bits [16*i+15:16*i].
dsp_r  in  1  DSP is accessing the shared RAM; high means the FPGA must not write.
addr_w  out  10  shared-RAM write address.
ram_din  out  16  shared-RAM write data.
ram_we  out  1  shared-RAM write enable.
xint_n  out  1  interrupt to DSP, active low.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when the interrupt pulse ends.
overrun  out  1  one-cycle pulse when start arrives while a request is already pending.

Behaviour:
- Reset values: addr_w=BASE_ADDR, ram_din=0, ram_we=0, xint_n=1, busy=0, done=0, overrun=0. Sequence counter=0, pending=0, state=IDLE. Reset mid-frame aborts the frame; no checksum word is written.
- States: IDLE, WAIT_BUS, WRITE, INT.
- IDLE: leaves on start or pending. On leaving, latch status_flat into an internal snapshot, clear pending, and go to WAIT_BUS.
- WAIT_BUS: if dsp_r=0, go to WRITE with word index k=0. Otherwise stay.
- WRITE: each cycle with dsp_r=0 drives ram_we=1, addr_w=BASE_ADDR+k, and ram_din=word k, then increments k.
  - Word 0 is the sequence counter.
  - Words 1..NUM-2 are snapshot words 0..NUM-3.
  - Word NUM-1 is ~sum, where sum is the 16-bit wrap-around sum of words 0..NUM-2, accumulated as they are written.
- dsp_r=1 during WRITE: ram_we=0 that cycle; k, addr_w and the sum hold; resume when dsp_r falls.
- Zero-stall frame: start in IDLE at cycle T means the first write occurs at T+2 and the last at T+NUM+1.
- After word NUM-1 is written: ram_we=0, xint_n=0 for exactly INT_WIDTH cycles (state INT), then xint_n=1.
  - In the same cycle xint_n returns to 1: done=1, the sequence counter increments (wraps 16'hFFFF to 0), and state returns to IDLE.
- start while busy: set pending. If pending is already set, pulse overrun; at most one request is queued.
- start in the same cycle as done: treated as pending and serviced from IDLE on the next cycle.
- Snapshot is taken once per frame; status_flat changes during the frame do not alter it.

Decomposition:
- Shared package: frame constants (NUM, BASE_ADDR, INT_WIDTH, CLK_HZ) and state encodings, shared with the receive path so both ends agree on frame length and checksum rule.
- Natural sub-module: frame_csum (16-bit accumulator with clear/enable, outputs ~sum). It is reusable by the receive checker.

Test Plan:
- Reset, then start with status word i = i+1 (i=0..29): RAM at 0x040..0x05F = 0x0000, 0x0001..0x001E, then ~(0x01D1)=0xFE2E. xint_n low for 100 cycles, then a done pulse.
- Second frame with the same data: word 0=0x0001 and checksum=0xFE2D. Then force the counter to 0xFFFF: the next frame sends 0xFFFF and the following frame sends 0x0000.
- dsp_r high at start for 20 cycles, then a 5-cycle dsp_r pulse mid-WRITE: no ram_we while dsp_r=1, addresses contiguous with no skip or duplicate, checksum unchanged.
- start pulses at frame cycle 10 and 12: first sets pending with no overrun, second pulses overrun. Exactly one extra frame follows, beginning the cycle after done.
- Reset asserted at word 15: next cycle ram_we=0, xint_n=1, busy=0, addr_w=0x040. No interrupt is generated and the sequence counter is 0.
- Scoreboard: a model of the receive checker recomputes the checksum on every frame and must never flag an error.
